// File: rtl/ltpi_nl_gpio_pattern_checker.sv
// LTPI NL GPIO pattern checker: drives an incrementing pattern and compares loopback.
// Define LTPI_GPIO_CHK_CAPTURE_EN to build the first-mismatch capture registers.
module ltpi_nl_gpio_pattern_checker #(
  parameter int GPIO_W        = 16,
  parameter int PERIOD_CYCLES = 5000000,
  parameter int SETTLE_CYCLES = 250000,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aligned,
  input  logic              nl_gpio_stable,
  input  logic              clear,
  input  logic [GPIO_W-1:0] gpio_rx,
  output logic [GPIO_W-1:0] gpio_tx,
  output logic [CNT_W-1:0]  chk_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              pass,
  output logic              heartbeat,
  output logic              first_err_valid,
  output logic [GPIO_W-1:0] first_err_exp,
  output logic [GPIO_W-1:0] first_err_rcv
);

  localparam int TMR_W = $clog2(PERIOD_CYCLES + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRIVE  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  localparam logic [TMR_W-1:0] SETTLE_T = TMR_W'(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] LAST_T   = TMR_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic [TMR_W-1:0] timer;
  logic             link_up;
  logic             mismatch;
  logic [CNT_W-1:0] chk_nx;
  logic [CNT_W-1:0] err_nx;

  assign link_up  = aligned & nl_gpio_stable;
  assign mismatch = (state == CHECK) && (gpio_rx != gpio_tx);

  // Timer reads 0 during DRIVE, so DRIVE-to-DRIVE spacing is PERIOD_CYCLES.
  always_comb begin
    nxt = state;
    if (!link_up) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    nxt = DRIVE;
        DRIVE:   nxt = SETTLE;
        SETTLE:  if (timer == SETTLE_T) nxt = CHECK;
        CHECK:   nxt = (timer == LAST_T) ? DRIVE : HOLD;
        HOLD:    if (timer == LAST_T) nxt = DRIVE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    chk_nx = chk_count;
    err_nx = err_count;
    if (clear) begin
      chk_nx = '0;
      err_nx = '0;
    end else if (state == CHECK) begin
      if (chk_count != CNT_MAX) chk_nx = chk_count + 1'b1;
      if (mismatch && err_count != CNT_MAX) err_nx = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      gpio_tx   <= '0;
      heartbeat <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == IDLE || nxt == DRIVE) timer <= '0;
      else timer <= timer + 1'b1;
      if (nxt == IDLE) gpio_tx <= '0;
      else if (state == DRIVE) gpio_tx <= gpio_tx + 1'b1;
      if (state == DRIVE) heartbeat <= ~heartbeat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_count <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      chk_count <= chk_nx;
      err_count <= err_nx;
      pass      <= (chk_nx != '0) && (err_nx == '0);
    end
  end

`ifdef LTPI_GPIO_CHK_CAPTURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_rcv   <= '0;
    end else if (clear) begin
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_rcv   <= '0;
    end else if (mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_exp   <= gpio_tx;
      first_err_rcv   <= gpio_rx;
    end
  end
`else
  assign first_err_valid = 1'b0;
  assign first_err_exp   = '0;
  assign first_err_rcv   = '0;
`endif

endmodule

// File: tb/tb_ltpi_nl_gpio_pattern_checker.sv
// Directed bench for ltpi_nl_gpio_pattern_checker (GPIO_W=8, period 20, settle 5).
// Capture expectations follow LTPI_GPIO_CHK_CAPTURE_EN.
module tb_ltpi_nl_gpio_pattern_checker;

`ifdef LTPI_GPIO_CHK_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       aligned;
  logic       nl_gpio_stable;
  logic       clear;
  logic [7:0] gpio_rx;
  logic [7:0] gpio_tx;
  logic [3:0] chk_count;
  logic [3:0] err_count;
  logic       pass;
  logic       heartbeat;
  logic       first_err_valid;
  logic [7:0] first_err_exp;
  logic [7:0] first_err_rcv;

  logic [7:0] d1, d2;
  int         mode;
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= gpio_tx;
    d2 <= d1;
  end

  always_comb begin
    gpio_rx = d2;
    if (mode == 1) gpio_rx = d2 & 8'hF7;
    if (mode == 2) gpio_rx = 8'hFF;
  end

  ltpi_nl_gpio_pattern_checker #(
    .GPIO_W(8), .PERIOD_CYCLES(20), .SETTLE_CYCLES(5), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .aligned(aligned),
    .nl_gpio_stable(nl_gpio_stable), .clear(clear),
    .gpio_rx(gpio_rx), .gpio_tx(gpio_tx),
    .chk_count(chk_count), .err_count(err_count),
    .pass(pass), .heartbeat(heartbeat),
    .first_err_valid(first_err_valid),
    .first_err_exp(first_err_exp),
    .first_err_rcv(first_err_rcv)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tx"}, 64'(gpio_tx), 0);
    chk({tag, ".chk"}, 64'(chk_count), 0);
    chk({tag, ".err"}, 64'(err_count), 0);
    chk({tag, ".pass"}, 64'(pass), 0);
    chk({tag, ".hb"}, 64'(heartbeat), 0);
    chk({tag, ".fev"}, 64'(first_err_valid), 0);
    chk({tag, ".fexp"}, 64'(first_err_exp), 0);
    chk({tag, ".frcv"}, 64'(first_err_rcv), 0);
  endtask

  initial begin
    mode = 0;
    reset = 1'b1;
    aligned = 1'b0;
    nl_gpio_stable = 1'b0;
    clear = 1'b0;
    #1;
    chk_zero("rst");
    step(3);
    reset = 1'b0;
    step(2);
    chk("idle_tx", 64'(gpio_tx), 0);

    // loopback, 3 periods
    aligned = 1'b1;
    nl_gpio_stable = 1'b1;
    step(1);
    chk("e1_tx", 64'(gpio_tx), 0);
    step(1);
    chk("e2_tx", 64'(gpio_tx), 1);
    chk("e2_hb", 64'(heartbeat), 1);
    step(19);
    chk("e21_tx", 64'(gpio_tx), 1);
    step(1);
    chk("e22_tx", 64'(gpio_tx), 2);
    chk("e22_hb", 64'(heartbeat), 0);
    step(20);
    chk("e42_tx", 64'(gpio_tx), 3);
    step(5);
    chk("e47_chk", 64'(chk_count), 2);
    step(1);
    chk("e48_chk", 64'(chk_count), 3);
    chk("e48_err", 64'(err_count), 0);
    chk("e48_pass", 64'(pass), 1);

    // async reset mid-HOLD
    step(3);
    reset = 1'b1;
    #1;
    chk_zero("rst_hold");
    #3;
    reset = 1'b0;

    // bit3 stuck at 0
    mode = 1;
    step(1);
    step(1);
    chk("f2_tx", 64'(gpio_tx), 1);
    step(145);
    chk("f147_chk", 64'(chk_count), 7);
    chk("f147_err", 64'(err_count), 0);
    step(1);
    chk("f148_err", 64'(err_count), 1);
    chk("f148_fev", 64'(first_err_valid), 64'(CAP));
    chk("f148_fexp", 64'(first_err_exp), CAP ? 8 : 0);
    chk("f148_frcv", 64'(first_err_rcv), 0);
    step(39);
    chk("f187_err", 64'(err_count), 2);
    step(1);
    chk("f188_chk", 64'(chk_count), 10);
    chk("f188_err", 64'(err_count), 3);
    chk("f188_pass", 64'(pass), 0);
    chk("f188_fexp", 64'(first_err_exp), CAP ? 8 : 0);

    // drop aligned during SETTLE
    step(15);
    chk("f203_tx", 64'(gpio_tx), 11);
    aligned = 1'b0;
    step(1);
    chk("drop_tx", 64'(gpio_tx), 0);
    chk("drop_chk", 64'(chk_count), 10);
    chk("drop_err", 64'(err_count), 3);
    step(3);
    chk("idle2_tx", 64'(gpio_tx), 0);
    aligned = 1'b1;
    step(1);
    chk("g1_tx", 64'(gpio_tx), 0);
    step(1);
    chk("g2_tx", 64'(gpio_tx), 1);

    // clear on a mismatching CHECK
    mode = 2;
    step(5);
    chk("g7_chk", 64'(chk_count), 10);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_chk", 64'(chk_count), 0);
    chk("clr_err", 64'(err_count), 0);
    chk("clr_pass", 64'(pass), 0);
    chk("clr_fev", 64'(first_err_valid), 0);
    chk("clr_fexp", 64'(first_err_exp), 0);

    // saturation with rx stuck at 0xFF
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(1);
    step(1);
    chk("h2_tx", 64'(gpio_tx), 1);
    step(6);
    chk("h8_chk", 64'(chk_count), 1);
    chk("h8_err", 64'(err_count), 1);
    chk("h8_fev", 64'(first_err_valid), 64'(CAP));
    chk("h8_fexp", 64'(first_err_exp), CAP ? 1 : 0);
    chk("h8_frcv", 64'(first_err_rcv), CAP ? 8'hFF : 0);
    step(260);
    chk("h268_chk", 64'(chk_count), 14);
    step(20);
    chk("h288_chk", 64'(chk_count), 15);
    chk("h288_err", 64'(err_count), 15);
    step(100);
    chk("sat_chk", 64'(chk_count), 15);
    chk("sat_err", 64'(err_count), 15);
    chk("sat_pass", 64'(pass), 0);
    chk("sat_fexp", 64'(first_err_exp), CAP ? 1 : 0);
    chk("sat_frcv", 64'(first_err_rcv), CAP ? 8'hFF : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ltpi_nl_gpio_pattern_checker.md
LTPI_NL_GPIO_PATTERN_CHECKER -- requirements
Module: ltpi_nl_gpio_pattern_checker

Interface
REQ-001 Parameter GPIO_W, default 16, is the pattern width in NL GPIO bits (legal 1..64).
REQ-002 Parameter PERIOD_CYCLES, default 5000000, is the clock cycles between pattern updates.
REQ-003 Parameter SETTLE_CYCLES, default 250000, is the cycles from pattern update to compare (legal 1..PERIOD_CYCLES-2).
REQ-004 Parameter CNT_W, default 16, is the width of the check and error counters.
REQ-005 clk  in  1  sole clock (controller 60 MHz domain); one clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 aligned  in  1  LTPI link aligned.
REQ-008 nl_gpio_stable  in  1  NL GPIO channel stable.
REQ-009 clear  in  1  synchronous pulse; zeroes counters and capture.
REQ-010 gpio_rx  in  GPIO_W  received NL GPIO (controller nl_gpio_out), same clock domain.
REQ-011 gpio_tx  out  GPIO_W  driven pattern (controller nl_gpio_in).
REQ-012 chk_count  out  CNT_W  completed compares, saturating.
REQ-013 err_count  out  CNT_W  mismatching compares, saturating.
REQ-014 pass  out  1  high when chk_count != 0 and err_count == 0.
REQ-015 heartbeat  out  1  toggles on every DRIVE cycle (LED).
REQ-016 first_err_valid, first_err_exp[GPIO_W], first_err_rcv[GPIO_W]  out  first-mismatch capture.

Function
REQ-017 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK, HOLD.
REQ-018 link_up = aligned AND nl_gpio_stable; when link_up is low in any state, the next state SHALL be IDLE.
REQ-019 IDLE: gpio_tx = 0, pattern register = 0, timer = 0; exit to DRIVE when link_up is high.
REQ-020 DRIVE (one cycle): pattern <= pattern + 1 modulo 2^GPIO_W, registered onto gpio_tx; timer = 0; heartbeat toggles; go to SETTLE.
REQ-021 Timer SHALL increment by 1 every cycle in SETTLE, CHECK and HOLD.
REQ-022 SETTLE -> CHECK when timer == SETTLE_CYCLES.
REQ-023 CHECK (one cycle): compare gpio_rx with gpio_tx; chk_count += 1; on mismatch err_count += 1; go to HOLD.
REQ-024 HOLD -> DRIVE when timer == PERIOD_CYCLES-1, so DRIVE-to-DRIVE spacing SHALL be exactly PERIOD_CYCLES cycles.
REQ-025 The first gpio_tx value after leaving IDLE SHALL be 1; the pattern wraps from all-ones to 0.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 clear in the same cycle as CHECK: clear wins; counters are 0 next cycle and that compare result is discarded.
REQ-028 clear SHALL NOT affect FSM, timer or pattern.
REQ-029 All outputs SHALL be registered (zero combinational paths from inputs to outputs).

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, gpio_tx = 0, timer = 0, chk_count = 0, err_count = 0, pass = 0, heartbeat = 0, and all capture outputs = 0, including mid-period.
REQ-031 After reset deasserts, the first DRIVE SHALL occur one cycle after the first clock edge that sees link_up high.

Configuration
REQ-032 Macro LTPI_GPIO_CHK_CAPTURE_EN SHALL gate the first-mismatch capture feature.
REQ-033 With the macro defined: the first mismatching CHECK since reset or clear latches gpio_tx into first_err_exp and gpio_rx into first_err_rcv, and sets first_err_valid; these hold until reset or clear.
REQ-034 Without the macro: first_err_valid, first_err_exp and first_err_rcv are tied to 0, and no capture registers are built.

Verification (GPIO_W=8, PERIOD_CYCLES=20, SETTLE_CYCLES=5, CNT_W=4)
REQ-035 Link up; gpio_rx = gpio_tx delayed 2 cycles -> gpio_tx steps 1, 2, 3 at 20-cycle spacing; after 3 checks, chk_count=3, err_count=0, pass=1.
REQ-036 gpio_rx bit3 stuck at 0 with loopback, 10 periods -> patterns 8, 9, 10 fail; err_count=3, chk_count=10, pass=0.
REQ-037 aligned dropped during SETTLE -> IDLE next cycle, gpio_tx=0, counters unchanged; on re-assert, the next gpio_tx is 1.
REQ-038 clear pulsed on a mismatching CHECK cycle -> chk_count=0 and err_count=0 next cycle; async reset mid-HOLD -> all outputs 0 with no clock edge.
REQ-039 gpio_rx tied to 0xFF for 20 periods -> err_count and chk_count saturate at 15; with LTPI_GPIO_CHK_CAPTURE_EN, first_err_exp=0x01, first_err_rcv=0xFF, held through later errors; without the macro, the capture outputs stay 0.
